// File: rtl/mem_responder.sv
// Memory-side responder for the BIST controller: single-outstanding write/read
// over req/ack, self-clearing array after reset, stuck-at fault injection on read data.
module mem_responder #(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int rd_latency = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ad_width-1:0]   addr,
    input  logic [data_width-1:0] wdata,
    input  logic                  fi_en,
    input  logic [data_width-1:0] fi_mask,
    input  logic [data_width-1:0] fi_val,
    output logic                  ack,
    output logic [data_width-1:0] rdata,
    output logic                  busy
);

    localparam int                  DEPTH  = 2 ** ad_width;
    localparam logic [ad_width-1:0] AD_MAX = ad_width'(DEPTH - 1);
    localparam logic [3:0]          LAT_M1 = 4'(rd_latency - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WACK  = 3'd2,
        S_RWAIT = 3'd3,
        S_RRESP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ad_width-1:0]   init_cnt_q, init_cnt_d;
    logic [3:0]            lat_cnt_q, lat_cnt_d;
    logic [ad_width-1:0]   addr_q, addr_d;
    logic                  fi_en_q, fi_en_d;
    logic [data_width-1:0] fi_mask_q, fi_mask_d;
    logic [data_width-1:0] fi_val_q, fi_val_d;
    logic                  ack_q, ack_d;
    logic [data_width-1:0] rdata_q, rdata_d;

    logic                  mem_we_s;
    logic [ad_width-1:0]   mem_waddr_s;
    logic [data_width-1:0] mem_wdata_s;
    logic [data_width-1:0] mem [DEPTH];

    // Masked bits take fi_val; the stored word itself is never touched.
    function automatic logic [data_width-1:0] apply_fault(
        input logic [data_width-1:0] data,
        input logic                  en,
        input logic [data_width-1:0] mask,
        input logic [data_width-1:0] val
    );
        logic [data_width-1:0] m;
        m = en ? mask : {data_width{1'b0}};
        return (data & ~m) | (val & m);
    endfunction

    // Next-state, capture and array-write decode.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        fi_en_d     = fi_en_q;
        fi_mask_d   = fi_mask_q;
        fi_val_d    = fi_val_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = init_cnt_q;
        mem_wdata_s = {data_width{1'b0}};
        case (state_q)
            S_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = init_cnt_q;
                if (init_cnt_q == AD_MAX) begin
                    state_d    = S_IDLE;
                    init_cnt_d = {ad_width{1'b0}};
                end else begin
                    init_cnt_d = init_cnt_q + ad_width'(1);
                end
            end
            S_IDLE: begin
                if (req) begin
                    addr_d    = addr;
                    fi_en_d   = fi_en;
                    fi_mask_d = fi_mask;
                    fi_val_d  = fi_val;
                    if (we) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = addr;
                        mem_wdata_s = wdata;
                        state_d     = S_WACK;
                        ack_d       = 1'b1;
                    end else begin
                        lat_cnt_d = LAT_M1;
                        // Single-cycle latency responds straight from the live inputs.
                        if (rd_latency == 1) begin
                            state_d = S_RRESP;
                            ack_d   = 1'b1;
                            rdata_d = apply_fault(mem[addr], fi_en, fi_mask, fi_val);
                        end else begin
                            state_d = S_RWAIT;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WACK: begin
                state_d = S_IDLE;
            end
            S_RWAIT: begin
                if (lat_cnt_q <= 4'd1) begin
                    state_d = S_RRESP;
                    ack_d   = 1'b1;
                    rdata_d = apply_fault(mem[addr_q], fi_en_q, fi_mask_q, fi_val_q);
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_RRESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_INIT;
                init_cnt_d = {ad_width{1'b0}};
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= {ad_width{1'b0}};
            lat_cnt_q  <= 4'd0;
            addr_q     <= {ad_width{1'b0}};
            fi_en_q    <= 1'b0;
            fi_mask_q  <= {data_width{1'b0}};
            fi_val_q   <= {data_width{1'b0}};
            ack_q      <= 1'b0;
            rdata_q    <= {data_width{1'b0}};
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            fi_en_q    <= fi_en_d;
            fi_mask_q  <= fi_mask_d;
            fi_val_q   <= fi_val_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage array; cleared by the INIT sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != S_IDLE);

endmodule
